// File: rtl/div_unit_pkg.sv
// Shared processor definitions for the divider: ALU opcodes, divider FSM states
// and small opcode-decoding helpers.
package div_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_DIV  = 5'b01111,
        ALU_DIVU = 5'b10000,
        ALU_REM  = 5'b10001,
        ALU_REMU = 5'b10010
    } aluop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_unit_if;
    logic        START;
    logic [4:0]  ALUOP;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        KILL;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    modport master (output START, ALUOP, DATA1, DATA2, KILL, input BUSY, DONE, RESULT);
    modport slave  (input START, ALUOP, DATA1, DATA2, KILL, output BUSY, DONE, RESULT);
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// conditionally subtract the divisor.
module div_step (
    input  logic [31:0] rem_in,
    input  logic        dvd_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);
    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        // No borrow means the divisor fits; the remainder stays below the divisor so 32 bits suffice.
        q_bit   = ~diff[33];
        rem_out = diff[33] ? shifted[31:0] : diff[31:0];
    end
endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider: fast paths for divide-by-zero and signed overflow,
// otherwise 32 restoring steps on magnitudes followed by one sign-fix cycle.
module div_unit
    import div_unit_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    div_unit_if.slave  bus
);
    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] result_q, result_d;

    logic [31:0] step_rem;
    logic        step_q;
    logic        start_ok;
    logic        sgn_op;
    logic        a_neg;
    logic        b_neg;

    div_step u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[31]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        start_ok = bus.START && is_div_op(bus.ALUOP);
        sgn_op   = is_signed_op(bus.ALUOP);
        a_neg    = sgn_op && bus.DATA1[31];
        b_neg    = sgn_op && bus.DATA2[31];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_ok) begin
                    op_d      = bus.ALUOP;
                    dvd_d     = a_neg ? (32'd0 - bus.DATA1) : bus.DATA1;
                    dvs_d     = b_neg ? (32'd0 - bus.DATA2) : bus.DATA2;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    quo_d     = '0;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (bus.DATA2 == 32'd0) begin
                        result_d = is_rem_op(bus.ALUOP) ? bus.DATA1 : 32'hFFFF_FFFF;
                        state_d  = ST_DONE;
                    end else if (sgn_op && bus.DATA1 == 32'h8000_0000 && bus.DATA2 == 32'hFFFF_FFFF) begin
                        result_d = is_rem_op(bus.ALUOP) ? 32'd0 : 32'h8000_0000;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                quo_d = {quo_q[30:0], step_q};
                rem_d = step_rem;
                dvd_d = {dvd_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_rem_op(op_q)) result_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
                else                 result_d = neg_quo_q ? (32'd0 - quo_q) : quo_q;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A flush drops the operation without touching the visible result.
        if (bus.KILL) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign bus.BUSY   = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign bus.DONE   = (state_q == ST_DONE);
    assign bus.RESULT = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: timing, signed/unsigned results, fast
// paths, KILL/RESET aborts, ignored START and back-to-back operation.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    div_unit_if bus();

    div_unit dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one request and wait (bounded) for DONE; cyc counts edges after E0.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cyc, output logic busy_seen);
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = op; bus.DATA1 = a; bus.DATA2 = b;
        @(posedge clk); #1;
        bus.START = 1'b0;
        cyc = 0;
        busy_seen = bus.BUSY;
        while (bus.DONE !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.BUSY === 1'b1) busy_seen = 1'b1;
        end
        res = bus.RESULT;
    endtask

    task automatic test_reset();
        bus.START = 1'b0; bus.KILL = 1'b0; bus.ALUOP = 5'd0; bus.DATA1 = '0; bus.DATA2 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.BUSY); else pass_cnt++;
        total_cnt++;
        if (bus.DONE !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.DONE); else pass_cnt++;
        total_cnt++;
        if (bus.RESULT !== 32'd0) $display("FAIL reset_result got=%h exp=0", bus.RESULT); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_div_basic();
        logic [31:0] res; int cyc; logic bs;
        run_op(ALU_DIV, 32'd100, 32'd7, res, cyc, bs);
        total_cnt++;
        if (res !== 32'd14) $display("FAIL div_100_7 got=%h exp=%h", res, 32'd14); else pass_cnt++;
        total_cnt++;
        if (cyc != 33) $display("FAIL div_latency got=%0d exp=33", cyc); else pass_cnt++;
        total_cnt++;
        if (bs !== 1'b1) $display("FAIL div_busy got=%b exp=1", bs); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.DONE !== 1'b0) $display("FAIL done_one_cycle got=%b exp=0", bus.DONE); else pass_cnt++;
        total_cnt++;
        if (bus.RESULT !== 32'd14) $display("FAIL result_hold got=%h exp=%h", bus.RESULT, 32'd14); else pass_cnt++;
        $display("div 100/7 -> %h in %0d cycles", res, cyc);
    endtask

    task automatic test_signed();
        logic [31:0] res; int cyc; logic bs;
        run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, res, cyc, bs);
        total_cnt++;
        if (res !== 32'hFFFF_FFFF) $display("FAIL rem_m7_2 got=%h exp=ffffffff", res); else pass_cnt++;
        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, res, cyc, bs);
        total_cnt++;
        if (res !== 32'hFFFF_FFFD) $display("FAIL div_m7_2 got=%h exp=fffffffd", res); else pass_cnt++;
        run_op(ALU_DIVU, 32'hFFFF_FFF9, 32'd2, res, cyc, bs);
        total_cnt++;
        if (res !== 32'h7FFF_FFFC) $display("FAIL divu_big_2 got=%h exp=7ffffffc", res); else pass_cnt++;
        run_op(ALU_REMU, 32'hFFFF_FFF9, 32'd2, res, cyc, bs);
        total_cnt++;
        if (res !== 32'd1) $display("FAIL remu_big_2 got=%h exp=1", res); else pass_cnt++;
        run_op(ALU_DIV, 32'hFFFF_FF9C, 32'd7, res, cyc, bs);
        total_cnt++;
        if (res !== 32'hFFFF_FFF2) $display("FAIL div_m100_7 got=%h exp=fffffff2", res); else pass_cnt++;
        run_op(ALU_REM, 32'd100, 32'hFFFF_FFF9, res, cyc, bs);
        total_cnt++;
        if (res !== 32'd2) $display("FAIL rem_100_m7 got=%h exp=2", res); else pass_cnt++;
        $display("signed vectors done, last result %h", res);
    endtask

    task automatic test_div_zero();
        logic [31:0] res; int cyc; logic bs;
        run_op(ALU_DIVU, 32'd5, 32'd0, res, cyc, bs);
        total_cnt++;
        if (res !== 32'hFFFF_FFFF) $display("FAIL divu_zero got=%h exp=ffffffff", res); else pass_cnt++;
        total_cnt++;
        if (cyc != 0) $display("FAIL divu_zero_lat got=%0d exp=0", cyc); else pass_cnt++;
        total_cnt++;
        if (bs !== 1'b0) $display("FAIL divu_zero_busy got=%b exp=0", bs); else pass_cnt++;
        run_op(ALU_REMU, 32'd5, 32'd0, res, cyc, bs);
        total_cnt++;
        if (res !== 32'd5) $display("FAIL remu_zero got=%h exp=5", res); else pass_cnt++;
        run_op(ALU_REM, 32'hFFFF_FFFD, 32'd0, res, cyc, bs);
        total_cnt++;
        if (res !== 32'hFFFF_FFFD) $display("FAIL rem_zero got=%h exp=fffffffd", res); else pass_cnt++;
        $display("divide-by-zero vectors done, last result %h", res);
    endtask

    task automatic test_overflow();
        logic [31:0] res; int cyc; logic bs;
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, cyc, bs);
        total_cnt++;
        if (res !== 32'h8000_0000) $display("FAIL div_ovf got=%h exp=80000000", res); else pass_cnt++;
        total_cnt++;
        if (cyc != 0) $display("FAIL div_ovf_lat got=%0d exp=0", cyc); else pass_cnt++;
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, cyc, bs);
        total_cnt++;
        if (res !== 32'd0) $display("FAIL rem_ovf got=%h exp=0", res); else pass_cnt++;
        run_op(ALU_REMU, 32'h8000_0000, 32'hFFFF_FFFF, res, cyc, bs);
        total_cnt++;
        if (res !== 32'h8000_0000) $display("FAIL remu_ovf got=%h exp=80000000", res); else pass_cnt++;
        total_cnt++;
        if (cyc != 33) $display("FAIL remu_ovf_lat got=%0d exp=33", cyc); else pass_cnt++;
        $display("overflow vectors done, last result %h", res);
    endtask

    task automatic test_invalid_op();
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = 5'b00000; bus.DATA1 = 32'd10; bus.DATA2 = 32'd2;
        @(posedge clk); #1;
        bus.START = 1'b0;
        total_cnt++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0)
            $display("FAIL invalid_op busy=%b done=%b exp=0/0", bus.BUSY, bus.DONE);
        else pass_cnt++;
        $display("invalid opcode ignored check done");
    endtask

    task automatic test_start_ignored();
        int cyc;
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = ALU_DIVU; bus.DATA1 = 32'd50; bus.DATA2 = 32'd5;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.START = 1'b1; bus.DATA1 = 32'd99; bus.DATA2 = 32'd9;
        @(posedge clk); #1;
        bus.START = 1'b0;
        cyc = 4;
        while (bus.DONE !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        total_cnt++;
        if (bus.RESULT !== 32'd10) $display("FAIL start_ignored got=%h exp=a", bus.RESULT); else pass_cnt++;
        total_cnt++;
        if (cyc != 33) $display("FAIL start_ignored_lat got=%0d exp=33", cyc); else pass_cnt++;
        $display("start while busy -> %h in %0d cycles", bus.RESULT, cyc);
    endtask

    task automatic test_kill();
        logic [31:0] res; int cyc; logic bs;
        run_op(ALU_DIVU, 32'd20, 32'd4, res, cyc, bs);
        total_cnt++;
        if (res !== 32'd5) $display("FAIL pre_kill got=%h exp=5", res); else pass_cnt++;
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = ALU_DIVU; bus.DATA1 = 32'd1000; bus.DATA2 = 32'd3;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.KILL = 1'b1;
        @(posedge clk); #1;
        bus.KILL = 1'b0;
        total_cnt++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0)
            $display("FAIL kill_state busy=%b done=%b exp=0/0", bus.BUSY, bus.DONE);
        else pass_cnt++;
        total_cnt++;
        if (bus.RESULT !== 32'd5) $display("FAIL kill_result got=%h exp=5", bus.RESULT); else pass_cnt++;
        run_op(ALU_DIVU, 32'd9, 32'd3, res, cyc, bs);
        total_cnt++;
        if (res !== 32'd3) $display("FAIL after_kill got=%h exp=3", res); else pass_cnt++;
        total_cnt++;
        if (cyc != 33) $display("FAIL after_kill_lat got=%0d exp=33", cyc); else pass_cnt++;
        $display("kill then 9/3 -> %h in %0d cycles", res, cyc);
    endtask

    task automatic test_reset_mid();
        logic done_seen;
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = ALU_DIV; bus.DATA1 = 32'd100; bus.DATA2 = 32'd7;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.RESULT !== 32'd0)
            $display("FAIL reset_mid busy=%b done=%b result=%h exp=0/0/0", bus.BUSY, bus.DONE, bus.RESULT);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.DONE === 1'b1) done_seen = 1'b1;
        end
        total_cnt++;
        if (done_seen !== 1'b0) $display("FAIL reset_mid_done got=%b exp=0", done_seen); else pass_cnt++;
        $display("reset mid-operation check done");
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = ALU_DIV; bus.DATA1 = 32'd100; bus.DATA2 = 32'd7;
        @(posedge clk); #1;
        bus.START = 1'b0;
        cyc = 0;
        while (bus.DONE !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        total_cnt++;
        if (bus.RESULT !== 32'd14 || cyc != 33)
            $display("FAIL b2b_first result=%h cyc=%0d exp=e/33", bus.RESULT, cyc);
        else pass_cnt++;
        bus.START = 1'b1; bus.ALUOP = ALU_REMU; bus.DATA1 = 32'd100; bus.DATA2 = 32'd7;
        @(posedge clk); #1;
        bus.START = 1'b0;
        total_cnt++;
        if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0)
            $display("FAIL b2b_no_bubble busy=%b done=%b exp=1/0", bus.BUSY, bus.DONE);
        else pass_cnt++;
        cyc = 0;
        while (bus.DONE !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        total_cnt++;
        if (bus.RESULT !== 32'd2) $display("FAIL b2b_second got=%h exp=2", bus.RESULT); else pass_cnt++;
        total_cnt++;
        if (cyc != 33) $display("FAIL b2b_second_lat got=%0d exp=33", cyc); else pass_cnt++;
        $display("back-to-back second -> %h in %0d cycles", bus.RESULT, cyc);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_div_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_invalid_op();
        test_start_ignored();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
